// File: rtl/gtfwizard_raw_drp_reconfig_ctrl.sv
// gtfwizard_raw_drp_reconfig_ctrl
//
// Reprograms the GTF RX phase-alignment mode. A rising edge on drp_reconfig_rdy_in
// starts two read-modify-write DRP transactions (register 0, then register 1). Each
// write selects either auto-mode or manual-mode field values, depending on
// drp_switch_am_in as sampled at the start edge. The DRP port is shared with a user
// master through a req/gnt handshake. When the sequence ends, drp_reconfig_done_out
// is raised and stays high until the request level drops.
//
// Ports (all synchronous to gtwiz_drp_reconfig_clk_in):
//   gtwiz_drp_reconfig_reset_in  synchronous active-high reset
//   drp_reconfig_rdy_in          request level from the buffer-bypass controller
//   drp_switch_am_in             1 = auto-mode values, 0 = manual-mode values
//   drp_reconfig_done_out        reconfiguration complete
//   drp_reconfig_error_out       sticky DRP timeout flag
//   drp_req_out / drp_gnt_in     DRP port ownership handshake
//   drpaddr_out, drpdi_out, drpen_out, drpwe_out, drpdo_in, drprdy_in  DRP port
//   sm_drp_reconfig_out          current FSM state (debug)
module gtfwizard_raw_drp_reconfig_ctrl #(
  parameter logic [9:0]  P_ADDR_0      = 10'h000,
  parameter logic [15:0] P_MASK_0      = 16'h0000,
  parameter logic [15:0] P_AM_VAL_0    = 16'h0000,
  parameter logic [15:0] P_MM_VAL_0    = 16'h0000,
  parameter logic [9:0]  P_ADDR_1      = 10'h000,
  parameter logic [15:0] P_MASK_1      = 16'h0000,
  parameter logic [15:0] P_AM_VAL_1    = 16'h0000,
  parameter logic [15:0] P_MM_VAL_1    = 16'h0000,
  parameter int unsigned P_DRP_TIMEOUT = 1023
) (
  input  logic        gtwiz_drp_reconfig_clk_in,
  input  logic        gtwiz_drp_reconfig_reset_in,
  input  logic        drp_reconfig_rdy_in,
  input  logic        drp_switch_am_in,
  output logic        drp_reconfig_done_out,
  output logic        drp_reconfig_error_out,
  output logic        drp_req_out,
  input  logic        drp_gnt_in,
  output logic [9:0]  drpaddr_out,
  output logic [15:0] drpdi_out,
  output logic        drpen_out,
  output logic        drpwe_out,
  input  logic [15:0] drpdo_in,
  input  logic        drprdy_in,
  output logic [2:0]  sm_drp_reconfig_out
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitGnt = 3'd1,
    StRd      = 3'd2,
    StWaitRd  = 3'd3,
    StWr      = 3'd4,
    StWaitWr  = 3'd5,
    StDone    = 3'd6
  } state_e;

  // The counter holds the number of wait cycles already spent without drprdy. When it
  // holds TIMEOUT-1 and drprdy is still low, this cycle is the one that reaches TIMEOUT.
  localparam logic [15:0] LP_CNT_LAST = 16'(P_DRP_TIMEOUT - 1);

  state_e      r_state, w_state_d;
  logic        r_rdy;
  logic        r_mode, w_mode_d;
  logic        r_idx, w_idx_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic        r_req, w_req_d;
  logic        r_done, w_done_d;
  logic        r_err, w_err_d;
  logic [9:0]  r_addr, w_addr_d;
  logic [15:0] r_di, w_di_d;
  logic        r_en, w_en_d;
  logic        r_we, w_we_d;

  logic        w_start;
  logic [15:0] w_mask;
  logic [15:0] w_val;
  logic [15:0] w_wdata;

  assign w_start = drp_reconfig_rdy_in & ~r_rdy;
  assign w_mask  = r_idx ? P_MASK_1 : P_MASK_0;
  assign w_val   = r_idx ? (r_mode ? P_AM_VAL_1 : P_MM_VAL_1)
                         : (r_mode ? P_AM_VAL_0 : P_MM_VAL_0);
  assign w_wdata = (drpdo_in & ~w_mask) | (w_val & w_mask);

  always_comb begin
    w_state_d = r_state;
    w_mode_d  = r_mode;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    w_req_d   = r_req;
    w_done_d  = r_done;
    w_err_d   = r_err;
    w_addr_d  = r_addr;
    w_di_d    = r_di;
    w_en_d    = 1'b0;
    w_we_d    = 1'b0;
    // Strobes and address/data are registered on the transition into RD/WR so that
    // drpen_out is high exactly during the RD or WR state.
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_mode_d  = drp_switch_am_in;
          w_idx_d   = 1'b0;
          w_req_d   = 1'b1;
          w_state_d = StWaitGnt;
        end
      end
      StWaitGnt: begin
        if (drp_gnt_in) begin
          w_en_d    = 1'b1;
          w_addr_d  = r_idx ? P_ADDR_1 : P_ADDR_0;
          w_state_d = StRd;
        end
      end
      StRd: begin
        w_cnt_d   = 16'd0;
        w_state_d = StWaitRd;
      end
      StWaitRd: begin
        if (drprdy_in) begin
          w_di_d    = w_wdata;
          w_en_d    = 1'b1;
          w_we_d    = 1'b1;
          w_state_d = StWr;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_err_d   = 1'b1;
          w_done_d  = 1'b1;
          w_req_d   = 1'b0;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StWr: begin
        w_cnt_d   = 16'd0;
        w_state_d = StWaitWr;
      end
      StWaitWr: begin
        if (drprdy_in) begin
          if (r_idx) begin
            w_done_d  = 1'b1;
            w_req_d   = 1'b0;
            w_state_d = StDone;
          end else begin
            w_idx_d   = 1'b1;
            w_en_d    = 1'b1;
            w_addr_d  = P_ADDR_1;
            w_state_d = StRd;
          end
        end else if (r_cnt == LP_CNT_LAST) begin
          w_err_d   = 1'b1;
          w_done_d  = 1'b1;
          w_req_d   = 1'b0;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StDone: begin
        if (!drp_reconfig_rdy_in) begin
          w_done_d  = 1'b0;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge gtwiz_drp_reconfig_clk_in) begin
    if (gtwiz_drp_reconfig_reset_in) begin
      r_state <= StIdle;
      r_rdy   <= 1'b0;
      r_mode  <= 1'b0;
      r_idx   <= 1'b0;
      r_cnt   <= 16'd0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 10'd0;
      r_di    <= 16'd0;
      r_en    <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_rdy   <= drp_reconfig_rdy_in;
      r_mode  <= w_mode_d;
      r_idx   <= w_idx_d;
      r_cnt   <= w_cnt_d;
      r_req   <= w_req_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
      r_addr  <= w_addr_d;
      r_di    <= w_di_d;
      r_en    <= w_en_d;
      r_we    <= w_we_d;
    end
  end

  assign drp_reconfig_done_out  = r_done;
  assign drp_reconfig_error_out = r_err;
  assign drp_req_out            = r_req;
  assign drpaddr_out            = r_addr;
  assign drpdi_out              = r_di;
  assign drpen_out              = r_en;
  assign drpwe_out              = r_we;
  assign sm_drp_reconfig_out    = r_state;

endmodule

// File: doc/gtfwizard_raw_drp_reconfig_ctrl.md
Name: gtfwizard_raw_drp_reconfig_ctrl

Overview:
- DRP sequencer that reconfigures the GTF RX phase-alignment mode when the RX buffer-bypass controller requests it.
- On a rising edge of the controller's reconfig-ready flag it performs two read-modify-write DRP transactions. The written values select auto mode or manual mode, as chosen by the controller's switch-AM flag.
- It then returns a reconfig-done flag.
- It shares the channel DRP port with a user DRP master through a request/grant handshake. It sits between the buffer-bypass controller and the DRP arbiter, in the DRP clock domain.

Parameters:
- P_ADDR_0, 10'h000: DRP address of register 0.
- P_MASK_0, 16'h0000: bit mask of the field modified in register 0.
- P_AM_VAL_0, 16'h0000: register 0 field value for auto mode.
- P_MM_VAL_0, 16'h0000: register 0 field value for manual mode.
- P_ADDR_1, P_MASK_1, P_AM_VAL_1, P_MM_VAL_1: same as above, for register 1.
- P_DRP_TIMEOUT, 1023: maximum cycles to wait for drprdy per transaction (range 1..65535).

Ports:
- gtwiz_drp_reconfig_clk_in  in  1  DRP clock; every input is synchronous to it.
- gtwiz_drp_reconfig_reset_in  in  1  Reset; synchronous, active-high.
- drp_reconfig_rdy_in  in  1  Request level from the buffer-bypass controller.
- drp_switch_am_in  in  1  1 = program auto-mode values, 0 = program manual-mode values. Sampled at the request edge.
- drp_reconfig_done_out  out  1  Reconfiguration complete.
- drp_reconfig_error_out  out  1  Sticky flag: a DRP timeout occurred.
- drp_req_out  out  1  Request for ownership of the DRP port.
- drp_gnt_in  in  1  Grant from the DRP arbiter.
- drpaddr_out  out  10  DRP address.
- drpdi_out  out  16  DRP write data.
- drpen_out  out  1  DRP enable.
- drpwe_out  out  1  DRP write enable.
- drpdo_in  in  16  DRP read data.
- drprdy_in  in  1  DRP ready.
- sm_drp_reconfig_out  out  3  Current FSM state, for debug.

Behaviour:
- Reset state: every output is 0, the FSM is in IDLE, idx=0, the timeout counter is 0, and the rdy edge register is 0. Asserting reset mid-sequence drops drp_req_out and drpen_out on the next edge. No transaction is resumed after reset.
- Edge detect: rdy_reg <= drp_reconfig_rdy_in. start = drp_reconfig_rdy_in & ~rdy_reg. start is acted on only in IDLE.
- State encoding: IDLE=0, WAIT_GNT=1, RD=2, WAIT_RD=3, WR=4, WAIT_WR=5, DONE=6.
- IDLE: on start, latch mode <= drp_switch_am_in, set idx <= 0, set drp_req_out <= 1, and go to WAIT_GNT.
- WAIT_GNT: when drp_gnt_in = 1, go to RD. drp_req_out stays 1 from here through WAIT_WR. drp_gnt_in is not rechecked after this state.
- RD: drive a one-cycle drpen_out=1 with drpwe_out=0 and drpaddr_out = ADDR[idx], then go to WAIT_RD.
- WAIT_RD: when drprdy_in = 1, capture wdata = (drpdo_in & ~MASK[idx]) | (VAL[idx] & MASK[idx]). VAL is AM_VAL when mode=1 and MM_VAL when mode=0. Then go to WR.
- WR: drive a one-cycle drpen_out=1 and drpwe_out=1, with drpaddr_out = ADDR[idx] and drpdi_out = wdata. Go to WAIT_WR.
- WAIT_WR: when drprdy_in = 1:
  - if idx=1, go to DONE;
  - otherwise set idx <= 1 and go to RD.
- Address/data hold: drpaddr_out and drpdi_out hold their last values between transactions. Only drpen_out and drpwe_out are strobes.
- Timeout: the counter clears on entry to WAIT_RD or WAIT_WR and increments every cycle while drprdy_in = 0. When it reaches P_DRP_TIMEOUT:
  - drp_reconfig_error_out is set to 1 and stays 1 until reset;
  - any remaining transactions are abandoned;
  - the FSM goes to DONE.
  If drprdy_in arrives in the same cycle the counter reaches P_DRP_TIMEOUT, drprdy_in wins and no error is set.
- drprdy_in outside WAIT_RD/WAIT_WR is ignored.
- DONE: drp_req_out <= 0 and drp_reconfig_done_out <= 1.
  - Done stays 1 while drp_reconfig_rdy_in = 1.
  - The first cycle in DONE that sees drp_reconfig_rdy_in = 0 clears done on the next edge and returns to IDLE.
  - Done is therefore high for at least 1 cycle. If rdy_in dropped mid-sequence, done is a 1-cycle pulse.
  - Done is asserted even after a timeout, so the upstream FSM never hangs.
- Request edges outside IDLE: a new rdy edge during any state other than IDLE is ignored. rdy must fall and rise again after returning to IDLE.
- Latency, from the start edge to done=1: 1 cycle (IDLE), plus grant wait, plus 2 × (RD + read wait + WR + write wait), plus 1 cycle.

Test Plan:
- Happy path: mode=1, zero-latency grant, drprdy 2 cycles after each drpen, P_ADDR_0=10'h05C, P_MASK_0=16'h0030, P_AM_VAL_0=16'h0010, drpdo=16'hFFFF. Required: write data 16'hFFDF to 10'h05C; both registers written; done=1 exactly 14 cycles after the rdy rise; req falls together with done rising; done held until rdy=0, then 0 one cycle later.
- Manual mode: mode=0, P_MM_VAL_1=16'h0000, P_MASK_1=16'h8000, drpdo=16'h8001. Required: write 16'h0001 to P_ADDR_1.
- Grant delayed 20 cycles: no drpen before grant; req held high throughout; mode still taken from the value latched at the rdy edge, even though switch_am toggles during the wait.
- Timeout: P_DRP_TIMEOUT=8 and drprdy never returned on the first read. Required: error=1 after 8 wait cycles, no write issued, done=1, error sticky across a second request.
- Boundary cases: drprdy arriving on the timeout cycle gives no error; rdy pulsed high again during WAIT_WR is ignored; rdy dropped mid-sequence gives a 1-cycle done pulse.
- Reset mid-sequence: assert reset during WAIT_WR. Required: all outputs 0 on the next edge, FSM=IDLE; a fresh rdy rise restarts from idx 0.
